key_debouncer: RTL and testbench

- Upstream conditioning stage between raw board push-buttons/switches (active-low, asynchronous, bouncing) and the lab top-level key inputs.
- Per input: two-flop synchronizer, debounce counter, clean active-high level, one-cycle press/release event pulses.
- Instantiated once per board top, in place of the direct inversion of the raw key bus.

---
 rtl/key_debouncer.sv | 159 +++++++++++++++
 tb/tb_key_debouncer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// Per-key conditioning of raw active-low board keys: 2-flop synchronizer, debounce counter,
// clean active-high level and one-cycle press/release pulses. Auto-repeat: KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer #(
    parameter int unsigned clk_mhz          = 50,
    parameter int unsigned w_key            = 7,
    parameter int unsigned debounce_ms      = 10,
    parameter int unsigned repeat_delay_ms  = 500,
    parameter int unsigned repeat_period_ms = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_key-1:0] key_n_in,
    output logic [w_key-1:0] key,
    output logic [w_key-1:0] key_press,
    output logic [w_key-1:0] key_release,
    output logic             any_key
);

    localparam int unsigned db_raw  = clk_mhz * 1000 * debounce_ms;
    localparam int unsigned db      = (db_raw < 1) ? 1 : db_raw;
    localparam int unsigned cw      = $clog2(db + 1);
    localparam logic [cw-1:0] db_last = cw'(db - 1);

    logic [w_key-1:0] sync1_q, sync2_q;
    logic [w_key-1:0] s;
    logic [w_key-1:0] key_q, key_d;
    logic [w_key-1:0] press_q, press_d;
    logic [w_key-1:0] rel_q, rel_d;
    logic [w_key-1:0] press_evt;
    logic             any_q;
    logic [cw-1:0]    cnt_q [w_key];
    logic [cw-1:0]    cnt_d [w_key];

    assign s = ~sync2_q;

    // A change is accepted on the cycle its run of differing samples would reach db.
    always_comb begin
        for (int i = 0; i < w_key; i++) begin
            cnt_d[i] = '0;
            key_d[i] = key_q[i];
            if (s[i] != key_q[i]) begin
                if (cnt_q[i] == db_last) begin
                    key_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + cw'(1);
                end
            end
        end
    end

    assign press_evt = key_d & ~key_q;
    assign rel_d     = key_q & ~key_d;

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int unsigned rd_raw = clk_mhz * 1000 * repeat_delay_ms;
    localparam int unsigned rp_raw = clk_mhz * 1000 * repeat_period_ms;
    localparam int unsigned rd     = (rd_raw < 1) ? 1 : rd_raw;
    localparam int unsigned rp     = (rp_raw < 1) ? 1 : rp_raw;
    localparam int unsigned rcw    = $clog2(((rd > rp) ? rd : rp) + 1);
    localparam logic [rcw-1:0] rd_last = rcw'(rd - 1);
    localparam logic [rcw-1:0] rp_last = rcw'(rp - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    rep_state_e       st_q [w_key];
    rep_state_e       st_d [w_key];
    logic [rcw-1:0]   rcnt_q [w_key];
    logic [rcw-1:0]   rcnt_d [w_key];
    logic [w_key-1:0] rep_pulse;

    // Driven from key_d so the release cycle itself can never emit a repeat pulse.
    always_comb begin
        for (int i = 0; i < w_key; i++) begin
            st_d[i]      = st_q[i];
            rcnt_d[i]    = rcnt_q[i];
            rep_pulse[i] = 1'b0;
            if (!key_d[i]) begin
                st_d[i]   = StIdle;
                rcnt_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    StIdle: begin
                        if (press_evt[i]) begin
                            st_d[i]   = StDelay;
                            rcnt_d[i] = '0;
                        end
                    end
                    StDelay: begin
                        if (rcnt_q[i] == rd_last) begin
                            rep_pulse[i] = 1'b1;
                            st_d[i]      = StRepeat;
                            rcnt_d[i]    = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + rcw'(1);
                        end
                    end
                    StRepeat: begin
                        if (rcnt_q[i] == rp_last) begin
                            rep_pulse[i] = 1'b1;
                            rcnt_d[i]    = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + rcw'(1);
                        end
                    end
                    default: st_d[i] = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < w_key; i++) begin
                st_q[i]   <= StIdle;
                rcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < w_key; i++) begin
                st_q[i]   <= st_d[i];
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign press_d = press_evt | rep_pulse;
`else
    assign press_d = press_evt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            key_q   <= '0;
            press_q <= '0;
            rel_q   <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < w_key; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_n_in;
            sync2_q <= sync1_q;
            key_q   <= key_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            any_q   <= |key_d;
            for (int i = 0; i < w_key; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key         = key_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign any_key     = any_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed and random key activity checked every cycle against a
// timestamp-based model (accept when the synchronized level has been stable for DB cycles).
module tb_key_debouncer;

    localparam int W  = 7;
    localparam int DB = 1000;
    localparam int RD = 5000;
    localparam int RP = 2000;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    localparam int EXP_P4 = 5;
`else
    localparam int EXP_P4 = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] key_n;
    logic [W-1:0] key, key_press, key_release;
    logic         any_key;

    key_debouncer #(
        .clk_mhz         (1),
        .w_key           (W),
        .debounce_ms     (1),
        .repeat_delay_ms (5),
        .repeat_period_ms(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n_in   (key_n),
        .key        (key),
        .key_press  (key_press),
        .key_release(key_release),
        .any_key    (any_key)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    logic [W-1:0] prev1, prev2, key_m, press_m, rel_m;
    bit           s_last [W];
    int           run_start [W];
    int           press_t [W];
    int           press_cnt [W];
    int           both13;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev1   = '1;
        prev2   = '1;
        key_m   = '0;
        press_m = '0;
        rel_m   = '0;
        for (int i = 0; i < W; i++) begin
            s_last[i]    = 1'b0;
            run_start[i] = cyc;
            press_t[i]   = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            press_m = '0;
            rel_m   = '0;
            for (int i = 0; i < W; i++) begin
                bit sv;
                sv = ~prev2[i];
                if (sv != s_last[i]) begin
                    s_last[i]    = sv;
                    run_start[i] = cyc;
                end
                if (sv != key_m[i] && cyc - run_start[i] + 1 >= DB) begin
                    key_m[i] = sv;
                    if (sv) begin
                        press_m[i] = 1'b1;
                        press_t[i] = cyc;
                    end else begin
                        rel_m[i] = 1'b1;
                    end
                end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
                else if (key_m[i] && cyc - press_t[i] >= RD &&
                         (cyc - press_t[i] - RD) % RP == 0) begin
                    press_m[i] = 1'b1;
                end
`endif
            end
            prev2 = prev1;
            prev1 = key_n;
        end
        #1;
        chk("cycle", {10'd0, key, key_press, key_release, any_key},
            {10'd0, key_m, press_m, rel_m, |key_m});
        for (int i = 0; i < W; i++) if (key_press[i]) press_cnt[i]++;
        if (key_press[1] && key_press[3]) both13++;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < W; i++) press_cnt[i] = 0;
        both13 = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = '1;
        clr_cnt();
        model_reset();
        ticks(3);
        chk("reset_outputs", {9'd0, key, key_press, key_release, any_key}, 32'd0);
        rst_n = 1'b1;
        ticks(3000);
        chk("idle_any_key", {31'd0, any_key}, 32'd0);

        // Clean press on key 0: captured at edge k, accepted at edge k+1001.
        clr_cnt();
        key_n[0] = 1'b0;
        ticks(1000);
        tick();
        chk("press_lat_before", {31'd0, key[0]}, 32'd0);
        tick();
        chk("press_lat_key", {31'd0, key[0]}, 32'd1);
        chk("press_lat_pulse", {31'd0, key_press[0]}, 32'd1);
        chk("press_lat_any", {31'd0, any_key}, 32'd1);
        tick();
        chk("press_pulse_width", {31'd0, key_press[0]}, 32'd0);
        ticks(100);
        key_n[0] = 1'b1;
        ticks(1100);
        chk("release_key0", {31'd0, key[0]}, 32'd0);
        chk("press_count0", press_cnt[0], 32'd1);

        // Bounce on key 2, then held pressed.
        clr_cnt();
        for (int j = 0; j < 10; j++) begin
            key_n[2] = (j % 2 == 0) ? 1'b0 : 1'b1;
            ticks(300);
        end
        chk("bounce_stable", {31'd0, key[2]}, 32'd0);
        key_n[2] = 1'b0;
        ticks(1200);
        chk("bounce_accept", {31'd0, key[2]}, 32'd1);
        chk("bounce_press_count", press_cnt[2], 32'd1);
        key_n[2] = 1'b1;
        ticks(1100);

        // Keys 1 and 3 pressed together.
        clr_cnt();
        key_n[1] = 1'b0;
        key_n[3] = 1'b0;
        ticks(1100);
        chk("simul_press", both13, 32'd1);

        // Reset mid-count with keys 5,6 counting; all held keys re-accepted DB+2 after release.
        key_n[5] = 1'b0;
        key_n[6] = 1'b0;
        ticks(500);
        rst_n = 1'b0;
        #1;
        chk("reset_async", {9'd0, key, key_press, key_release, any_key}, 32'd0);
        model_reset();
        ticks(5);
        rst_n = 1'b1;
        ticks(DB + 1);
        chk("held_reset_before", {31'd0, key[5]}, 32'd0);
        tick();
        chk("held_reset_accept", {25'd0, key}, {25'd0, 7'b1101010});
        ticks(50);
        key_n = '1;
        ticks(1200);

        // Long hold on key 4: auto-repeat pulses only when enabled.
        clr_cnt();
        key_n[4] = 1'b0;
        ticks(11500);
        key_n[4] = 1'b1;
        ticks(1200);
        chk("repeat_press_count", press_cnt[4], EXP_P4);

        // Random key activity.
        for (int seg = 0; seg < 25; seg++) begin
            key_n = W'($urandom);
            ticks(int'($urandom_range(50, 1500)));
        end
        key_n = '1;
        ticks(1200);
        chk("final_idle", {31'd0, any_key}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
